// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse definitions: header bit positions, frame states,
// display defaults shared with the VGA painter, cursor clamp helper.
package ps2_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int TIMEOUT_DEF = 100000;

    localparam int HB_LEFT  = 0;
    localparam int HB_RIGHT = 1;
    localparam int HB_SYNC  = 3;
    localparam int HB_XS    = 4;
    localparam int HB_YS    = 5;
    localparam int HB_XO    = 6;
    localparam int HB_YO    = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } frame_state_t;

    function automatic logic [9:0] clamp_axis(
        input logic signed [11:0] v,
        input int                 hi
    );
        int vi;
        vi = int'(v);
        if (vi < 0)
            return 10'd0;
        if (vi > hi)
            return 10'(hi);
        return 10'(vi);
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: pin synchronizers, falling-edge detect,
// 11-bit frame FSM with odd parity check and inactivity timeout.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       busy,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       byte_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]   clk_sync;
    logic [1:0]   dat_sync;
    logic         clk_prev;
    logic         fall;
    logic         din;
    logic         tmo;
    logic         run;
    logic [CW-1:0] cnt;
    frame_state_t state;
    frame_state_t state_n;
    logic [7:0]   shreg;
    logic [2:0]   bitcnt;
    logic         par_ok;
    logic         ok_n;
    logic         err_n;

    assign din     = dat_sync[1];
    assign fall    = clk_prev & ~clk_sync[1];
    assign tmo     = (cnt == CW'(TIMEOUT));
    assign run     = (state != S_IDLE) || busy;
    assign rx_byte = shreg;

    // Timeout outranks any edge seen in the same cycle.
    always_comb begin
        state_n = state;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        if (tmo) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
        end else if (fall) begin
            unique case (state)
                S_IDLE:   if (!din) state_n = S_DATA;
                S_DATA:   if (bitcnt == 3'd7) state_n = S_PARITY;
                S_PARITY: state_n = S_STOP;
                S_STOP: begin
                    state_n = S_IDLE;
                    if (din && par_ok)
                        ok_n = 1'b1;
                    else
                        err_n = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
            state    <= S_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            par_ok   <= 1'b0;
            byte_ok  <= 1'b0;
            byte_err <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
            state    <= state_n;
            byte_ok  <= ok_n;
            byte_err <= err_n;
            if (tmo || fall || !run)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (fall && !tmo) begin
                unique case (state)
                    S_IDLE:   bitcnt <= '0;
                    S_DATA: begin
                        shreg  <= {din, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                    end
                    S_PARITY: par_ok <= ^{shreg, din};
                    S_STOP:   ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: assembles 3-byte stream packets and keeps an
// absolute cursor clamped to the visible area plus button levels.
module ps2_mouse_tracker
    import ps2_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] xm,
    output logic [9:0] ym,
    output logic       left,
    output logic       right,
    output logic       pkt_valid,
    output logic       err
);

    logic [7:0]         rx_byte;
    logic               byte_ok;
    logic               byte_err;
    logic [1:0]         idx;
    logic [7:0]         hdr;
    logic [7:0]         dxb;
    logic signed [8:0]  dx;
    logic signed [8:0]  dy;
    logic signed [11:0] nx;
    logic signed [11:0] ny;
    logic [9:0]         xm_n;
    logic [9:0]         ym_n;
    logic               unused_hdr_bits;

    ps2_rx_byte #(
        .TIMEOUT(TIMEOUT)
    ) u_rx (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .busy      (idx != 2'd0),
        .rx_byte   (rx_byte),
        .byte_ok   (byte_ok),
        .byte_err  (byte_err)
    );

    assign unused_hdr_bits = hdr[HB_SYNC] ^ hdr[2];

    // PS/2 +Y points up while ym grows downward, hence the subtraction.
    always_comb begin
        dx   = {hdr[HB_XS], dxb};
        dy   = {hdr[HB_YS], rx_byte};
        nx   = $signed({2'b00, xm}) + $signed({{3{dx[8]}}, dx});
        ny   = $signed({2'b00, ym}) - $signed({{3{dy[8]}}, dy});
        xm_n = hdr[HB_XO] ? xm : clamp_axis(nx, H_RES - 1);
        ym_n = hdr[HB_YO] ? ym : clamp_axis(ny, V_RES - 1);
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            xm        <= 10'(H_RES / 2);
            ym        <= 10'(V_RES / 2);
            left      <= 1'b0;
            right     <= 1'b0;
            pkt_valid <= 1'b0;
            err       <= 1'b0;
            idx       <= 2'd0;
            hdr       <= '0;
            dxb       <= '0;
        end else begin
            pkt_valid <= 1'b0;
            err       <= 1'b0;
            if (byte_err) begin
                idx <= 2'd0;
                err <= 1'b1;
            end else if (byte_ok) begin
                unique case (idx)
                    2'd0: begin
                        if (rx_byte[HB_SYNC]) begin
                            hdr <= rx_byte;
                            idx <= 2'd1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    2'd1: begin
                        dxb <= rx_byte;
                        idx <= 2'd2;
                    end
                    default: begin
                        xm        <= xm_n;
                        ym        <= ym_n;
                        left      <= hdr[HB_LEFT];
                        right     <= hdr[HB_RIGHT];
                        pkt_valid <= 1'b1;
                        idx       <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench: PS/2 device model, directed vector table,
// hand-written timeout/reset sequences and randomized packets vs a model.
module tb_ps2_mouse_tracker;

    localparam int TMO = 300;
    localparam int HP  = 8;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic [9:0] xm;
    logic [9:0] ym;
    logic       left;
    logic       right;
    logic       pkt_valid;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;
    int npkt        = 0;
    int nerr        = 0;
    int nboth       = 0;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int nb, bad, kind;
        int x, y, l, r, dp, de;
    } vec_t;

    vec_t tab[$];

    always #5 clk_100MHz = ~clk_100MHz;

    ps2_mouse_tracker #(
        .H_RES  (640),
        .V_RES  (480),
        .TIMEOUT(TMO)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .xm        (xm),
        .ym        (ym),
        .left      (left),
        .right     (right),
        .pkt_valid (pkt_valid),
        .err       (err)
    );

    always @(negedge clk_100MHz) begin
        if (pkt_valid) npkt++;
        if (err) nerr++;
        if (pkt_valid && err) nboth++;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    // Data changes while ps2_clk is high; the host samples on the fall.
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HP);
        ps2_clk = 1'b0;
        tick(HP);
        ps2_clk = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop bit
    task automatic send_byte(input logic [7:0] b, input int kind, input int nbits);
        logic [10:0] fr;
        fr = {(kind != 2), (~^b) ^ (kind == 1), b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
        tick(2 * HP);
    endtask

    task automatic check_all(input string tag, input int x, input int y,
                             input int l, input int r, input int dp, input int de,
                             input int p0, input int e0);
        check({tag, " xm"}, int'(xm), x);
        check({tag, " ym"}, int'(ym), y);
        check({tag, " left"}, int'(left), l);
        check({tag, " right"}, int'(right), r);
        check({tag, " pkt_valid pulses"}, npkt - p0, dp);
        check({tag, " err pulses"}, nerr - e0, de);
    endtask

    task automatic run(input string tag, input logic [7:0] b0, b1, b2,
                       input int nb, bad, kind,
                       input int x, y, l, r, dp, de);
        logic [7:0] bs[3];
        int p0, e0;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        p0 = npkt;
        e0 = nerr;
        for (int j = 0; j < nb; j++) send_byte(bs[j], (j == bad) ? kind : 0, 11);
        tick(6);
        check_all(tag, x, y, l, r, dp, de, p0, e0);
    endtask

    task automatic add(input logic [7:0] b0, b1, b2, input int nb, bad, kind,
                       input int x, y, l, r, dp, de);
        vec_t v;
        v = '{b0, b1, b2, nb, bad, kind, x, y, l, r, dp, de};
        tab.push_back(v);
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    initial begin
        int p0, e0;
        int mx, my, ml, mr;

        //   b0     b1     b2   nb bad kd   xm   ym  l  r dp de
        add(8'h09, 8'h05, 8'h03, 3, -1, 0, 325, 237, 1, 0, 1, 0);
        add(8'h18, 8'h80, 8'h00, 3, -1, 0, 197, 237, 0, 0, 1, 0);
        add(8'h18, 8'h80, 8'h00, 3, -1, 0,  69, 237, 0, 0, 1, 0);
        add(8'h18, 8'hC5, 8'h00, 3, -1, 0,  10, 237, 0, 0, 1, 0);
        add(8'h18, 8'h80, 8'h00, 3, -1, 0,   0, 237, 0, 0, 1, 0);
        add(8'h08, 8'h7F, 8'h00, 3, -1, 0, 127, 237, 0, 0, 1, 0);
        add(8'h08, 8'h7F, 8'h00, 3, -1, 0, 254, 237, 0, 0, 1, 0);
        add(8'h28, 8'h00, 8'h17, 3, -1, 0, 254, 470, 0, 0, 1, 0);
        add(8'h28, 8'h00, 8'hF0, 3, -1, 0, 254, 479, 0, 0, 1, 0);
        add(8'h0A, 8'h00, 8'h00, 3, -1, 0, 254, 479, 0, 1, 1, 0);
        add(8'h08, 8'h00, 8'h10, 3, -1, 0, 254, 463, 0, 0, 1, 0);
        add(8'h09, 8'h05, 8'h03, 3,  1, 1, 254, 463, 0, 0, 0, 2);
        add(8'h09, 8'h05, 8'h03, 3, -1, 0, 259, 460, 1, 0, 1, 0);
        add(8'h01, 8'h00, 8'h00, 1, -1, 0, 259, 460, 1, 0, 0, 1);
        add(8'h18, 8'hF6, 8'h00, 3, -1, 0, 249, 460, 0, 0, 1, 0);
        add(8'h88, 8'h10, 8'h10, 3, -1, 0, 265, 460, 0, 0, 1, 0);
        add(8'h0B, 8'h00, 8'h00, 1,  0, 2, 265, 460, 0, 0, 0, 1);
        add(8'h0B, 8'h00, 8'h00, 3,  2, 2, 265, 460, 0, 0, 0, 1);
        add(8'h08, 8'hFF, 8'h00, 3, -1, 0, 520, 460, 0, 0, 1, 0);
        add(8'h08, 8'hFF, 8'h00, 3, -1, 0, 639, 460, 0, 0, 1, 0);
        add(8'h08, 8'h00, 8'hFF, 3, -1, 0, 639, 205, 0, 0, 1, 0);
        add(8'h08, 8'h00, 8'hFF, 3, -1, 0, 639,   0, 0, 0, 1, 0);
        add(8'h38, 8'h9C, 8'h9C, 3, -1, 0, 539, 100, 0, 0, 1, 0);

        tick(5);
        reset = 1'b0;
        tick(10);
        check_all("reset", 320, 240, 0, 0, 0, 0, 0, 0);

        foreach (tab[i])
            run($sformatf("row%0d", i), tab[i].b0, tab[i].b1, tab[i].b2,
                tab[i].nb, tab[i].bad, tab[i].kind, tab[i].x, tab[i].y,
                tab[i].l, tab[i].r, tab[i].dp, tab[i].de);

        p0 = npkt;
        e0 = nerr;
        send_byte(8'h08, 0, 11);
        send_byte(8'h00, 0, 11);
        send_byte(8'h10, 0, 5);
        tick(TMO + 40);
        check_all("timeout", 539, 100, 0, 0, 0, 1, p0, e0);

        run("x_overflow", 8'h48, 8'h10, 8'h10, 3, -1, 0, 539, 84, 0, 0, 1, 0);
        run("press", 8'h09, 8'h00, 8'h00, 3, -1, 0, 539, 84, 1, 0, 1, 0);

        p0 = npkt;
        e0 = nerr;
        send_byte(8'h5A, 0, 5);
        reset = 1'b1;
        tick(3);
        check_all("mid_reset", 320, 240, 0, 0, 0, 0, p0, e0);
        reset = 1'b0;
        tick(4);
        run("after_reset", 8'h09, 8'h05, 8'h03, 3, -1, 0, 325, 237, 1, 0, 1, 0);

        mx = 325; my = 237; ml = 1; mr = 0;
        for (int it = 0; it < 30; it++) begin
            int sel, k, dxv, dyv;
            logic [7:0] h, bx, by;
            sel = $urandom_range(0, 9);
            h   = 8'($urandom());
            bx  = 8'($urandom());
            by  = 8'($urandom());
            if (sel == 0) begin
                h[3] = 1'b0;
                run($sformatf("rnd%0d sync", it), h, bx, by, 1, -1, 0,
                    mx, my, ml, mr, 0, 1);
            end else if (sel == 1) begin
                h[3] = 1'b1;
                k = $urandom_range(0, 2);
                run($sformatf("rnd%0d bad", it), h, bx, by, k + 1, k,
                    $urandom_range(1, 2), mx, my, ml, mr, 0, 1);
            end else begin
                h[3] = 1'b1;
                dxv = h[4] ? int'(bx) - 256 : int'(bx);
                dyv = h[5] ? int'(by) - 256 : int'(by);
                if (!h[6]) mx = clampi(mx + dxv, 639);
                if (!h[7]) my = clampi(my - dyv, 479);
                ml = int'(h[0]);
                mr = int'(h[1]);
                run($sformatf("rnd%0d pkt", it), h, bx, by, 3, -1, 0,
                    mx, my, ml, mr, 1, 0);
            end
        end

        check("err with pkt_valid", nboth, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
